// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block: FSM encoding and size defaults.
package cam_pkg;

    localparam int CAM_AW           = 17;
    localparam int CAM_DW           = 16;
    localparam int CAM_FRAME_PIXELS = 76800;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_BYTE_HI    = 2'd2,
        ST_BYTE_LO    = 2'd3
    } cam_state_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for one camera control line, plus a third flop for edge detection.
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // NOTE: sequential state always uses <= so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/cam_capture.sv
// Camera byte-stream capture: pairs of bytes become RGB565 frame-buffer writes on clk.
// Defining CAM_CAPTURE_TESTPAT_EN adds input test_en, which replaces pixel data by an address pattern.
module cam_capture
    import cam_pkg::*;
#(
    parameter int AW           = CAM_AW,
    parameter int DW           = CAM_DW,
    parameter int FRAME_PIXELS = CAM_FRAME_PIXELS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pclk,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
`ifdef CAM_CAPTURE_TESTPAT_EN
    input  logic          test_en,
`endif
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          overflow
);

    logic       w_pclk_rise;
    logic       w_pclk_fall;
    logic       w_pclk_level;
    logic       w_vsync_rise;
    logic       w_vsync_fall;
    logic       w_vsync_level;
    logic       w_href;
    logic       w_href_rise;
    logic       w_href_fall;
    logic       w_unused_edges;

    cam_sync_edge u_sync_pclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (pclk),
        .o_level (w_pclk_level),
        .o_rise  (w_pclk_rise),
        .o_fall  (w_pclk_fall)
    );

    cam_sync_edge u_sync_vsync (
        .clk     (clk),
        .rst     (rst),
        .i_async (vsync),
        .o_level (w_vsync_level),
        .o_rise  (w_vsync_rise),
        .o_fall  (w_vsync_fall)
    );

    cam_sync_edge u_sync_href (
        .clk     (clk),
        .rst     (rst),
        .i_async (href),
        .o_level (w_href),
        .o_rise  (w_href_rise),
        .o_fall  (w_href_fall)
    );

    assign w_unused_edges = &{1'b0, w_pclk_fall, w_pclk_level, w_vsync_level, w_href_rise, w_href_fall};

    // Data bus goes through the same two-stage delay so it lines up with the synchronized pclk edge.
    logic [7:0] r_px_s1;
    logic [7:0] r_px_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_px_s1 <= '0;
            r_px_s2 <= '0;
        end else begin
            r_px_s1 <= px_data;
            r_px_s2 <= r_px_s1;
        end
    end

    cam_state_t    r_state;
    cam_state_t    w_state_nxt;
    logic          w_frame_start;
    logic          w_frame_end;
    logic          w_cap_hi;
    logic          w_cap_lo;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_cap_hi      = 1'b0;
        w_cap_lo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vsync_rise) begin
                    w_state_nxt   = ST_WAIT_FRAME;
                    w_frame_start = 1'b1;
                end
            end
            ST_WAIT_FRAME: begin
                if (w_vsync_fall) w_state_nxt = ST_BYTE_HI;
            end
            ST_BYTE_HI: begin
                if (w_vsync_rise) begin
                    w_state_nxt   = ST_WAIT_FRAME;
                    w_frame_start = 1'b1;
                    w_frame_end   = 1'b1;
                end else if (w_pclk_rise && w_href) begin
                    w_state_nxt = ST_BYTE_LO;
                    w_cap_hi    = 1'b1;
                end
            end
            ST_BYTE_LO: begin
                // vsync outranks a coincident pclk edge; a dropped href discards the half pixel.
                if (w_vsync_rise) begin
                    w_state_nxt   = ST_WAIT_FRAME;
                    w_frame_start = 1'b1;
                    w_frame_end   = 1'b1;
                end else if (!w_href) begin
                    w_state_nxt = ST_BYTE_HI;
                end else if (w_pclk_rise) begin
                    w_state_nxt = ST_BYTE_HI;
                    w_cap_lo    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    logic [AW-1:0] r_addr;
    logic [15:0]   r_data;
    logic          r_regwrite;
    logic          r_frame_done;
    logic          r_overflow;
    logic [15:0]   w_lo_data;
    logic          w_addr_full;

`ifdef CAM_CAPTURE_TESTPAT_EN
    assign w_lo_data = test_en ? {r_addr[7:0], ~r_addr[7:0]} : {r_data[15:8], r_px_s2};
`else
    assign w_lo_data = {r_data[15:8], r_px_s2};
`endif

    assign w_addr_full = (r_addr == AW'(FRAME_PIXELS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_regwrite   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_regwrite   <= 1'b0;
            r_frame_done <= w_frame_end;
            if (r_regwrite) r_addr <= r_addr + AW'(1);
            if (w_cap_hi) r_data[15:8] <= r_px_s2;
            if (w_cap_lo) begin
                r_data <= w_lo_data;
                if (w_addr_full) r_overflow <= 1'b1;
                else             r_regwrite <= 1'b1;
            end
            if (w_frame_start) begin
                r_addr     <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign addr_in    = r_addr;
    assign data_in    = DW'(r_data);
    assign regwrite   = r_regwrite;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture; a small FRAME_PIXELS keeps the overflow frame short.
`timescale 1ns/1ps
module tb_cam_capture;

    localparam int AW    = 17;
    localparam int DW    = 16;
    localparam int TB_FP = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          pclk;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
`ifdef CAM_CAPTURE_TESTPAT_EN
    logic          test_en;
`endif
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic          frame_done;
    logic          overflow;

    int n_cmp = 0;
    int n_mis = 0;

    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            fd_count   = 0;
    int            long_pulse = 0;
    logic          prev_wr    = 1'b0;

    cam_capture #(
        .AW           (AW),
        .DW           (DW),
        .FRAME_PIXELS (TB_FP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
`ifdef CAM_CAPTURE_TESTPAT_EN
        .test_en    (test_en),
`endif
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (regwrite === 1'b1) begin
            wr_addr.push_back(addr_in);
            wr_data.push_back(data_in);
            if (prev_wr === 1'b1) long_pulse++;
        end
        if (frame_done === 1'b1) fd_count++;
        prev_wr = regwrite;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        long_pulse = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic h);
        pclk    = 1'b0;
        px_data = b;
        href    = h;
        wait_clk(3);
        pclk    = 1'b1;
        wait_clk(3);
    endtask

    task automatic send_pixel(input logic [15:0] d);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
    endtask

    task automatic line_gap();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_clk(4);
    endtask

    task automatic vsync_pulse();
        href  = 1'b0;
        vsync = 1'b1;
        wait_clk(8);
        vsync = 1'b0;
        wait_clk(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(4);
        n_cmp++; if (addr_in !== '0)     begin n_mis++; $display("FAIL reset_addr: got %h want 0", addr_in); end
        n_cmp++; if (data_in !== '0)     begin n_mis++; $display("FAIL reset_data: got %h want 0", data_in); end
        n_cmp++; if (regwrite !== 1'b0)  begin n_mis++; $display("FAIL reset_regwrite: got %b want 0", regwrite); end
        n_cmp++; if (frame_done !== 1'b0) begin n_mis++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (overflow !== 1'b0)  begin n_mis++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_rgb_line();
        clear_log();
        vsync_pulse();
        send_byte(8'hF8, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'hE0, 1'b1);
        line_gap();
        n_cmp++; if (wr_addr.size() != 2) begin n_mis++; $display("FAIL rgb_count: got %0d want 2", wr_addr.size()); end
        n_cmp++; if (wr_addr[0] !== 17'd0) begin n_mis++; $display("FAIL rgb_addr0: got %h want 0", wr_addr[0]); end
        n_cmp++; if (wr_data[0] !== 16'hF800) begin n_mis++; $display("FAIL rgb_data0: got %h want f800", wr_data[0]); end
        n_cmp++; if (wr_addr[1] !== 17'd1) begin n_mis++; $display("FAIL rgb_addr1: got %h want 1", wr_addr[1]); end
        n_cmp++; if (wr_data[1] !== 16'h07E0) begin n_mis++; $display("FAIL rgb_data1: got %h want 07e0", wr_data[1]); end
        n_cmp++; if (long_pulse != 0) begin n_mis++; $display("FAIL rgb_pulse_width: got %0d long pulses want 0", long_pulse); end
        n_cmp++; if (addr_in !== 17'd2) begin n_mis++; $display("FAIL rgb_addr_after: got %h want 2", addr_in); end
        n_cmp++; if (fd_count != 0) begin n_mis++; $display("FAIL rgb_no_frame_done: got %0d want 0", fd_count); end
    endtask

    task automatic test_href_drop();
        clear_log();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        line_gap();
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        line_gap();
        n_cmp++; if (wr_addr.size() != 2) begin n_mis++; $display("FAIL href_count: got %0d want 2", wr_addr.size()); end
        n_cmp++; if (wr_data[0] !== 16'h1234) begin n_mis++; $display("FAIL href_data0: got %h want 1234", wr_data[0]); end
        n_cmp++; if (wr_addr[0] !== 17'd2) begin n_mis++; $display("FAIL href_addr0: got %h want 2", wr_addr[0]); end
        n_cmp++; if (wr_data[1] !== 16'hABCD) begin n_mis++; $display("FAIL href_data1: got %h want abcd", wr_data[1]); end
        n_cmp++; if (wr_addr[1] !== 17'd3) begin n_mis++; $display("FAIL href_addr1: got %h want 3", wr_addr[1]); end
    endtask

    task automatic test_frame_done();
        int fd0;
        int bad;
        fd0 = fd_count;
        vsync_pulse();
        n_cmp++; if (fd_count != fd0 + 1) begin n_mis++; $display("FAIL fd_first: got %0d want %0d", fd_count, fd0 + 1); end
        n_cmp++; if (addr_in !== 17'd0) begin n_mis++; $display("FAIL fd_addr_clear: got %h want 0", addr_in); end
        clear_log();
        for (int i = 0; i < 10; i++) send_pixel(16'h5A00 + 16'(i));
        line_gap();
        n_cmp++; if (wr_addr.size() != 10) begin n_mis++; $display("FAIL fd_count10: got %0d want 10", wr_addr.size()); end
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 17'(i) || wr_data[i] !== 16'h5A00 + 16'(i)) bad++;
        n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL fd_seq: %0d bad writes want 0", bad); end
        vsync_pulse();
        n_cmp++; if (fd_count != fd0 + 2) begin n_mis++; $display("FAIL fd_second: got %0d want %0d", fd_count, fd0 + 2); end
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL fd_overflow: got %b want 0", overflow); end
        clear_log();
        send_pixel(16'hBEEF);
        line_gap();
        n_cmp++; if (wr_addr.size() != 1) begin n_mis++; $display("FAIL fd_next_count: got %0d want 1", wr_addr.size()); end
        n_cmp++; if (wr_addr[0] !== 17'd0) begin n_mis++; $display("FAIL fd_next_addr: got %h want 0", wr_addr[0]); end
        n_cmp++; if (wr_data[0] !== 16'hBEEF) begin n_mis++; $display("FAIL fd_next_data: got %h want beef", wr_data[0]); end
    endtask

    task automatic test_overflow();
        int bad;
        vsync_pulse();
        clear_log();
        for (int i = 0; i < TB_FP; i++) send_pixel(16'h1000 + 16'(i));
        line_gap();
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL ovf_early: got %b want 0", overflow); end
        n_cmp++; if (addr_in !== 17'(TB_FP)) begin n_mis++; $display("FAIL ovf_addr_full: got %h want %h", addr_in, 17'(TB_FP)); end
        send_pixel(16'hDEAD);
        line_gap();
        n_cmp++; if (overflow !== 1'b1) begin n_mis++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_cmp++; if (wr_addr.size() != TB_FP) begin n_mis++; $display("FAIL ovf_count: got %0d want %0d", wr_addr.size(), TB_FP); end
        n_cmp++; if (addr_in !== 17'(TB_FP)) begin n_mis++; $display("FAIL ovf_addr_hold: got %h want %h", addr_in, 17'(TB_FP)); end
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 17'(i) || wr_data[i] !== 16'h1000 + 16'(i)) bad++;
        n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL ovf_seq: %0d bad writes want 0", bad); end
        vsync_pulse();
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        n_cmp++; if (addr_in !== 17'd0) begin n_mis++; $display("FAIL ovf_addr_clear: got %h want 0", addr_in); end
    endtask

    task automatic test_collision();
        int fd0;
        clear_log();
        fd0 = fd_count;
        send_byte(8'h11, 1'b1);
        pclk    = 1'b0;
        px_data = 8'h22;
        href    = 1'b1;
        wait_clk(3);
        vsync = 1'b1;
        pclk  = 1'b1;
        wait_clk(8);
        vsync = 1'b0;
        href  = 1'b0;
        wait_clk(8);
        n_cmp++; if (wr_addr.size() != 0) begin n_mis++; $display("FAIL coll_dropped: got %0d writes want 0", wr_addr.size()); end
        n_cmp++; if (fd_count != fd0 + 1) begin n_mis++; $display("FAIL coll_fd: got %0d want %0d", fd_count, fd0 + 1); end
        send_pixel(16'h3344);
        line_gap();
        n_cmp++; if (wr_addr.size() != 1) begin n_mis++; $display("FAIL coll_next_count: got %0d want 1", wr_addr.size()); end
        n_cmp++; if (wr_addr[0] !== 17'd0) begin n_mis++; $display("FAIL coll_next_addr: got %h want 0", wr_addr[0]); end
        n_cmp++; if (wr_data[0] !== 16'h3344) begin n_mis++; $display("FAIL coll_next_data: got %h want 3344", wr_data[0]); end
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        fd0 = fd_count;
        for (int i = 0; i < 5; i++) send_pixel(16'h7700 + 16'(i));
        rst = 1'b1;
        wait_clk(3);
        n_cmp++; if (addr_in !== '0)      begin n_mis++; $display("FAIL mrst_addr: got %h want 0", addr_in); end
        n_cmp++; if (data_in !== '0)      begin n_mis++; $display("FAIL mrst_data: got %h want 0", data_in); end
        n_cmp++; if (regwrite !== 1'b0)   begin n_mis++; $display("FAIL mrst_regwrite: got %b want 0", regwrite); end
        n_cmp++; if (frame_done !== 1'b0) begin n_mis++; $display("FAIL mrst_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (overflow !== 1'b0)   begin n_mis++; $display("FAIL mrst_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        wait_clk(2);
        clear_log();
        for (int i = 0; i < 3; i++) send_pixel(16'h6600 + 16'(i));
        line_gap();
        n_cmp++; if (wr_addr.size() != 0) begin n_mis++; $display("FAIL mrst_no_write: got %0d writes want 0", wr_addr.size()); end
        vsync_pulse();
        n_cmp++; if (fd_count != fd0) begin n_mis++; $display("FAIL mrst_no_fd: got %0d want %0d", fd_count, fd0); end
        send_pixel(16'h0F0F);
        line_gap();
        n_cmp++; if (wr_addr.size() != 1) begin n_mis++; $display("FAIL mrst_resume_count: got %0d want 1", wr_addr.size()); end
        n_cmp++; if (wr_addr[0] !== 17'd0) begin n_mis++; $display("FAIL mrst_resume_addr: got %h want 0", wr_addr[0]); end
        n_cmp++; if (wr_data[0] !== 16'h0F0F) begin n_mis++; $display("FAIL mrst_resume_data: got %h want 0f0f", wr_data[0]); end
    endtask

`ifdef CAM_CAPTURE_TESTPAT_EN
    task automatic test_testpat();
        test_en = 1'b1;
        vsync_pulse();
        clear_log();
        for (int i = 0; i < 4; i++) send_pixel(16'hC3C3);
        line_gap();
        n_cmp++; if (wr_addr.size() != 4) begin n_mis++; $display("FAIL tp_count: got %0d want 4", wr_addr.size()); end
        n_cmp++; if (wr_data[0] !== 16'h00FF) begin n_mis++; $display("FAIL tp_data0: got %h want 00ff", wr_data[0]); end
        n_cmp++; if (wr_addr[3] !== 17'd3) begin n_mis++; $display("FAIL tp_addr3: got %h want 3", wr_addr[3]); end
        n_cmp++; if (wr_data[3] !== 16'h03FC) begin n_mis++; $display("FAIL tp_data3: got %h want 03fc", wr_data[3]); end
        test_en = 1'b0;
    endtask
`endif

    initial begin
        rst     = 1'b1;
        pclk    = 1'b0;
        vsync   = 1'b0;
        href    = 1'b0;
        px_data = 8'h00;
`ifdef CAM_CAPTURE_TESTPAT_EN
        test_en = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_rgb_line();
        test_href_drop();
        test_frame_done();
        test_overflow();
        test_collision();
        test_reset_mid_frame();
`ifdef CAM_CAPTURE_TESTPAT_EN
        test_testpat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 The block SHALL have parameter AW, default 17, meaning frame-buffer address width.
REQ-002 The block SHALL have parameter DW, default 16, meaning pixel width (RGB565).
REQ-003 The block SHALL have parameter FRAME_PIXELS, default 76800, meaning pixels per frame (320x240).
REQ-004 The block SHALL have port clk  input  1  system clock; this is the only clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port pclk  input  1  camera pixel clock, sampled as data and not used as a clock.
REQ-007 The block SHALL have port vsync  input  1  camera vertical sync, high during vertical blank.
REQ-008 The block SHALL have port href  input  1  camera line-valid.
REQ-009 The block SHALL have port px_data  input  8  camera byte bus.
REQ-010 The block SHALL have port addr_in  output  AW  frame-buffer write address.
REQ-011 The block SHALL have port data_in  output  DW  frame-buffer write data.
REQ-012 The block SHALL have port regwrite  output  1  frame-buffer write strobe, one clk wide.
REQ-013 The block SHALL have port frame_done  output  1  one-clk pulse at the end of a captured frame.
REQ-014 The block SHALL have port overflow  output  1  sticky flag: more than FRAME_PIXELS pixels arrived in the current frame.

Function
REQ-015 pclk, vsync, href and px_data SHALL pass through a 2-flop synchronizer; a pclk rising edge SHALL be detected by comparing synchronizer stage 2 with a stage-3 copy; clk SHALL be at least 4x pclk.
REQ-016 The FSM SHALL have states IDLE, WAIT_FRAME, BYTE_HI, BYTE_LO.
REQ-017 IDLE -> WAIT_FRAME SHALL occur on the synchronized vsync rising edge; on this transition the address counter SHALL clear to 0 and overflow SHALL clear.
REQ-018 WAIT_FRAME -> BYTE_HI SHALL occur on the synchronized vsync falling edge.
REQ-019 In BYTE_HI, a pclk edge with href=1 SHALL latch px_data into data_in[15:8] and move to BYTE_LO.
REQ-020 In BYTE_LO, a pclk edge with href=1 SHALL latch px_data into data_in[7:0] and move to BYTE_HI; regwrite SHALL assert in the next clk cycle for exactly one cycle, with addr_in and data_in stable during that cycle.
REQ-021 addr_in SHALL increment by 1 in the clk cycle after each regwrite pulse.
REQ-022 When href is sampled low in BYTE_LO, the half pixel SHALL be discarded and the state SHALL return to BYTE_HI.
REQ-023 When addr_in equals FRAME_PIXELS, regwrite SHALL be suppressed, addr_in SHALL hold, and overflow SHALL set and remain set until the next frame start.
REQ-024 A vsync rising edge in BYTE_HI or BYTE_LO SHALL pulse frame_done for one cycle and SHALL move to WAIT_FRAME, clearing addr_in to 0 (wrap-around to the next frame).
REQ-025 A vsync edge and a pclk edge in the same cycle SHALL be resolved with vsync taking priority; the byte is dropped.
REQ-026 regwrite SHALL never assert outside BYTE_HI/BYTE_LO processing.

Reset
REQ-027 While rst=1, the block SHALL set state=IDLE, addr_in=0, data_in=0, regwrite=0, frame_done=0, overflow=0 and clear the synchronizer flops to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a frame_done pulse; capture SHALL resume only after the next vsync rising edge.

Configuration
REQ-029 With macro CAM_CAPTURE_TESTPAT_EN defined, the block SHALL add input test_en (1 bit); when test_en=1, the written data_in SHALL be {addr_in[7:0], ~addr_in[7:0]} and camera bytes SHALL be ignored, with timing unchanged.
REQ-030 Without CAM_CAPTURE_TESTPAT_EN, the test_en port and pattern logic SHALL be absent.

Structure
REQ-031 A shared package cam_pkg SHALL hold the FSM state encoding, FRAME_PIXELS, AW and DW defaults.
REQ-032 The synchronizer plus edge detector SHALL be one sub-module, cam_sync_edge, instantiated once per control signal (pclk, vsync, href).

Verification
REQ-033 Reset, vsync pulse, one line of 4 bytes 0xF8,0x00,0x07,0xE0 -> writes 0xF800 at addr 0 and 0x07E0 at addr 1, each with a 1-clk regwrite.
REQ-034 href drops after 3 bytes 0x12,0x34,0x56 -> one write of 0x1234; 0x56 is discarded; the next line starts at the high byte.
REQ-035 A frame of 76801 pixels -> 76800 writes (addresses 0..76799); overflow=1 after the 76801st pixel; no write at 76800.
REQ-036 vsync rises after 10 pixels -> frame_done pulses once; the next frame's first write is at addr 0 and overflow=0.
REQ-037 rst=1 after 5 pixels, then released -> all outputs 0; no write until the next vsync rising edge; no frame_done.
REQ-038 With CAM_CAPTURE_TESTPAT_EN defined and test_en=1 -> data at addr 0x00003 = 0x03FC.
